// File: rtl/prog_loader.sv
// prog_loader: writes a framed byte image (N, N data bytes, checksum) into program memory and holds the CPU in reset until it passes.
// Each accepted data byte is written one cycle later. in_ready is registered and stalled bytes are dropped. LOADER_READBACK_EN adds a readback verify pass.
module prog_loader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CSUM,
`ifdef LOADER_READBACK_EN
        VERIFY,
`endif
        DONE,
        ERR
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] sum;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] wptr;
    logic              accept;
    logic [DATA_W-1:0] sum_next;
    logic              len_bad;

    assign accept   = in_valid && in_ready;
    assign sum_next = sum + in_data;
    // Header is widened by one bit so N == 2^ADDR_W is still representable.
    assign len_bad  = (in_data == '0) || ({1'b0, in_data} > (DATA_W+1)'(DEPTH));

`ifdef LOADER_READBACK_EN
    logic [DATA_W-1:0] dsum;
    logic [DATA_W-1:0] rsum;
    logic [DATA_W-1:0] rsum_next;
    logic [ADDR_W:0]   len;
    logic              rd_vld;

    assign rsum_next = rd_vld ? rsum + mem_rdata : rsum;
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            sum       <= '0;
            count     <= '0;
            wptr      <= BASE;
`ifdef LOADER_READBACK_EN
            dsum      <= '0;
            rsum      <= '0;
            len       <= '0;
            rd_vld    <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                HDR: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        sum  <= in_data;
                        wptr <= BASE;
`ifdef LOADER_READBACK_EN
                        dsum <= '0;
                        len  <= in_data[ADDR_W:0];
`endif
                        if (len_bad) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            err_code <= 2'd1;
                            in_ready <= 1'b0;
                        end else begin
                            count <= in_data[ADDR_W:0];
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wptr;
                        mem_wdata <= in_data;
                        wptr      <= wptr + 1'b1;
                        sum       <= sum_next;
`ifdef LOADER_READBACK_EN
                        dsum      <= dsum + in_data;
`endif
                        count     <= count - 1'b1;
                        if (count == 1) state <= CSUM;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (sum_next == '0) begin
`ifdef LOADER_READBACK_EN
                            state    <= VERIFY;
                            mem_addr <= BASE;
                            count    <= len;
                            rsum     <= '0;
                            rd_vld   <= 1'b0;
`else
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state    <= ERR;
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end
                    end
                end
`ifdef LOADER_READBACK_EN
                // One address per cycle; read data trails its address by one cycle.
                VERIFY: begin
                    rsum <= rsum_next;
                    if (count != 0) begin
                        mem_addr <= mem_addr + 1'b1;
                        count    <= count - 1'b1;
                        rd_vld   <= 1'b1;
                    end else if (rsum_next == dsum) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= ERR;
                        err      <= 1'b1;
                        err_code <= 2'd3;
                    end
                end
`endif
                DONE: in_ready <= 1'b0;
                ERR:  in_ready <= 1'b0;
                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader; the writing side of the CPU's 32x8 program/data memory, which the CPU only fetches from.
- Accepts a framed image over a valid/ready byte interface and writes it into memory.
- Holds the CPU in reset (cpu_hold) until the image is loaded and its checksum passes.
- Sits between an external host link and the memory write port; it releases the program counter to start fetching at address 0.

Parameters:
- ADDR_W, 5, memory address width; capacity = 2^ADDR_W bytes.
- DATA_W, 8, memory word and stream byte width.
- BASE_ADDR, 0, first memory address written; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  host byte valid.
- in_data  in  DATA_W  host byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address, used for both write and readback.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid 1 cycle after mem_addr is presented.
- cpu_hold  out  1  high keeps the CPU in reset.
- done  out  1  load succeeded; sticky.
- err  out  1  load failed; sticky.
- err_code  out  2  failure cause: 0 none, 1 bad length, 2 checksum, 3 readback.

Behaviour:
- Reset values: state=HDR, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, err=0, err_code=0, sum=0, count=0.
- Reset mid-load returns to HDR with all outputs at reset values. Memory contents are not cleared.
- Frame format: header byte N (1..2^ADDR_W), then N data bytes, then 1 checksum byte.
- Checksum rule: the 8-bit sum of header + data + checksum must equal 0x00 (mod 256).
- A byte is accepted only when in_valid && in_ready. in_ready is registered; it is 1 in HDR, DATA and CSUM, and 0 otherwise.
- A stalled in_valid (held high while in_ready=0) is ignored and not buffered.
- State HDR:
  - Accept N; sum <= N.
  - If N==0 or N > 2^ADDR_W, go to ERR with code 1.
  - Otherwise count <= N and go to DATA.
- State DATA:
  - Data byte k (k=0..N-1) is written one cycle after acceptance: mem_we=1, mem_addr=BASE_ADDR+k (mod 2^ADDR_W), mem_wdata=byte.
  - mem_we is a single-cycle pulse per byte. Back-to-back bytes produce back-to-back write pulses.
  - sum and dsum (sum of data bytes only) accumulate, mod 256.
  - After the N-th byte is accepted, go to CSUM.
- State CSUM:
  - Accept the checksum byte.
  - If (sum + byte) mod 256 == 0, go to VERIFY when LOADER_READBACK_EN is defined, else go to DONE.
  - Otherwise go to ERR with code 2.
- State DONE: done=1, cpu_hold=0, in_ready=0. Remains here until rst.
- State ERR: err=1, err_code latched, cpu_hold=1, in_ready=0. Remains here until rst.
- Both DONE and ERR are entered on the edge after the deciding byte is accepted, so the outputs are visible 1 cycle after that acceptance.
- Latency: the last memory write lands before or in the same cycle that DONE is entered. cpu_hold never drops while a write is still pending.
- N == 2^ADDR_W fills memory exactly. The address wraps only when BASE_ADDR != 0.

Optional Feature:
- Macro: LOADER_READBACK_EN.
- Defined: after the checksum passes, the VERIFY state reads addresses BASE_ADDR..BASE_ADDR+N-1 with mem_we=0, one address per cycle.
  - mem_rdata is summed mod 256 one cycle after each address (N+1 cycles total).
  - If the readback sum equals dsum, go to DONE. Otherwise go to ERR with code 3.
  - cpu_hold stays 1 throughout VERIFY.
- Undefined: the VERIFY state and the mem_rdata logic are absent. mem_rdata is unused and err_code 3 is never produced.

Test Plan:
- Stream 03,11,22,33,97 with in_valid held high -> writes mem[0]=11, mem[1]=22, mem[2]=33 on consecutive cycles; done=1, cpu_hold=0, err=0.
- Same frame with checksum 98 -> no further writes after the data; err=1, err_code=2, cpu_hold=1, done=0.
- Header 00, then header 21 (after a rst between them) -> each gives err=1, err_code=1, no mem_we pulse.
- Frame 03,11,22,33,97 with in_valid toggling every other cycle, plus rst asserted after the second data byte, then the full frame resent -> first attempt aborts with outputs at reset values; second attempt gives done=1 with mem[0..2]=11,22,33.
- BASE_ADDR=30, frame 03,AA,BB,CC,CC -> writes mem[30]=AA, mem[31]=BB, mem[0]=CC; done=1.
- LOADER_READBACK_EN defined, memory model corrupts mem[1] to 23 -> VERIFY runs 4 cycles, then err=1, err_code=3; with an uncorrupted model, done=1.
